escape_time_iterator: RTL and testbench



---
 rtl/mandelbrot_pkg.sv | 18 +
 rtl/complex_square_step.sv | 39 +++
 rtl/escape_time_iterator.sv | 101 ++++++++++
 tb/tb_escape_time_iterator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared types and constants for the Mandelbrot escape-time datapath.
package mandelbrot_pkg;

  localparam int FRAC_BITS      = 29;
  localparam int COUNT_BITS     = 10;
  localparam int MAX_ITERATIONS = 1023;

  localparam logic signed [66:0] ESCAPE_LIMIT = 67'sd4 <<< FRAC_BITS;

  typedef logic signed [31:0] q3_29_t;
  typedef logic signed [32:0] q4_29_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_ITERATE = 1'b1
  } iter_state_t;

endpackage

// File: rtl/complex_square_step.sv
// One combinational z <- z^2 + c step plus |z|^2, kept apart so the multipliers can be retimed.
module complex_square_step
  import mandelbrot_pkg::q3_29_t;
  import mandelbrot_pkg::q4_29_t;
#(
  parameter int FRAC_BITS = 29
) (
  input  q4_29_t             zr,
  input  q4_29_t             zi,
  input  q3_29_t             cx,
  input  q3_29_t             cy,
  output q4_29_t             next_zr,
  output q4_29_t             next_zi,
  output logic signed [66:0] mag
);

  logic signed [65:0] zr_w;
  logic signed [65:0] zi_w;
  logic signed [65:0] zr_sq;
  logic signed [65:0] zi_sq;
  logic signed [32:0] zrzi;
  logic signed [32:0] cx_w;
  logic signed [32:0] cy_w;

  assign zr_w = {{33{zr[32]}}, zr};
  assign zi_w = {{33{zi[32]}}, zi};
  assign cx_w = {cx[31], cx};
  assign cy_w = {cy[31], cy};

  // Arithmetic shifts truncate each product toward -inf before any summing.
  assign zr_sq = (zr_w * zr_w) >>> FRAC_BITS;
  assign zi_sq = (zi_w * zi_w) >>> FRAC_BITS;
  assign zrzi  = 33'((zr_w * zi_w) >>> FRAC_BITS);

  assign mag     = {zr_sq[65], zr_sq} + {zi_sq[65], zi_sq};
  assign next_zr = 33'(zr_sq - zi_sq) + cx_w;
  assign next_zi = (zrzi <<< 1) + cy_w;

endmodule

// File: rtl/escape_time_iterator.sv
// Per-pixel escape-time engine: one z <- z^2 + c iteration per clock behind a req/ack/busy/done handshake.
module escape_time_iterator #(
  parameter int FRAC_BITS  = mandelbrot_pkg::FRAC_BITS,
  parameter int COUNT_BITS = mandelbrot_pkg::COUNT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  output logic                  ack,
  input  logic [31:0]           x,
  input  logic [31:0]           y,
  input  logic [COUNT_BITS-1:0] max_iterations,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_BITS-1:0] iteration_count_out
);
  import mandelbrot_pkg::*;

  localparam logic signed [66:0] ESC_LIMIT = 67'sd4 <<< FRAC_BITS;

  function automatic logic [COUNT_BITS-1:0] clamp_limit(input logic [COUNT_BITS-1:0] m);
    return (m == '0) ? COUNT_BITS'(1) : m;
  endfunction

  iter_state_t           state;
  q4_29_t                zr;
  q4_29_t                zi;
  q4_29_t                next_zr;
  q4_29_t                next_zi;
  q3_29_t                cx;
  q3_29_t                cy;
  logic signed [66:0]    mag;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] limit;

  complex_square_step #(
    .FRAC_BITS(FRAC_BITS)
  ) u_step (
    .zr     (zr),
    .zi     (zi),
    .cx     (cx),
    .cy     (cy),
    .next_zr(next_zr),
    .next_zi(next_zi),
    .mag    (mag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      ack                 <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      iteration_count_out <= '0;
      zr                  <= '0;
      zi                  <= '0;
      count               <= '0;
      cx                  <= '0;
      cy                  <= '0;
      limit               <= '0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            cx    <= x;
            cy    <= y;
            limit <= clamp_limit(max_iterations);
            zr    <= '0;
            zi    <= '0;
            count <= '0;
            ack   <= 1'b1;
            busy  <= 1'b1;
            state <= ST_ITERATE;
          end
        end
        ST_ITERATE: begin
          // |z|^2 == 4 exactly is still bounded; only strictly larger escapes.
          if (mag > ESC_LIMIT) begin
            done                <= 1'b1;
            busy                <= 1'b0;
            iteration_count_out <= count;
            state               <= ST_IDLE;
          end else if (count == limit) begin
            done                <= 1'b1;
            busy                <= 1'b0;
            iteration_count_out <= limit;
            state               <= ST_IDLE;
          end else begin
            zr    <= next_zr;
            zi    <= next_zi;
            count <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escape_time_iterator.sv
// Directed and randomised checks of escape_time_iterator against hand-computed counts and a Q3.29 model.
module tb_escape_time_iterator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        ack;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [9:0]  max_iterations = '0;
  logic        busy;
  logic        done;
  logic [9:0]  iteration_count_out;

  int checks = 0;
  int failures = 0;

  escape_time_iterator dut (
    .clk                (clk),
    .reset              (reset),
    .req                (req),
    .ack                (ack),
    .x                  (x),
    .y                  (y),
    .max_iterations     (max_iterations),
    .busy               (busy),
    .done               (done),
    .iteration_count_out(iteration_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after the acceptance edge; lat counts edges from E0 to the done edge.
  task automatic wait_done(input string tag, output int lat, output int nbusy, output int nack);
    lat = 0;
    nbusy = 0;
    nack = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      lat++;
      if (done) break;
      if (busy) nbusy++;
      if (ack) nack++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic int model(input logic signed [31:0] cx, input logic signed [31:0] cy, input int lim);
    logic signed [65:0] a, b, sr, si, pr;
    logic signed [65:0] four;
    logic signed [32:0] zr, zi;
    int n;
    four = 66'sd4 <<< 29;
    zr = '0;
    zi = '0;
    n = 0;
    if (lim == 0) lim = 1;
    forever begin
      a  = 66'(zr);
      b  = 66'(zi);
      sr = (a * a) >>> 29;
      si = (b * b) >>> 29;
      pr = (a * b) >>> 29;
      if (sr + si > four) return n;
      if (n == lim) return n;
      zr = 33'(sr - si + 66'(cx));
      zi = 33'(pr * 2 + 66'(cy));
      n++;
    end
  endfunction

  task automatic run_point(input string tag, input logic [31:0] cx, input logic [31:0] cy,
                           input logic [9:0] mx, input int exp);
    int lat, nb, na;
    x = cx;
    y = cy;
    max_iterations = mx;
    req = 1'b1;
    tick();
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    req = 1'b0;
    x = 32'hDEAD_BEEF;
    y = 32'h1234_5678;
    max_iterations = 10'd7;
    wait_done(tag, lat, nb, na);
    check({tag, "_count"}, 32'(iteration_count_out), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(exp + 1));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(nb + 1), 32'(exp + 1));
  endtask

  initial begin
    int lat, nb, na, exp;
    logic [31:0] r;
    logic signed [31:0] rx, ry;
    logic [9:0] rm;

    tick();
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(iteration_count_out), 32'd0);
    reset = 1'b0;
    tick();

    run_point("c0_max", 32'h0000_0000, 32'h0, 10'd1023, 1023);
    check("ack_cleared", 32'(ack), 32'd0);
    tick();
    tick();
    check("result_held", 32'(iteration_count_out), 32'd1023);
    run_point("c1_0", 32'h2000_0000, 32'h0, 10'd100, 3);
    run_point("c2_5", 32'h5000_0000, 32'h0, 10'd50, 1);
    run_point("cm2_0", 32'hC000_0000, 32'h0, 10'd20, 20);
    run_point("max0", 32'h0, 32'h0, 10'd0, 1);
    run_point("c0_5", 32'h1000_0000, 32'h0, 10'd100, 5);
    run_point("c_i", 32'h0, 32'h2000_0000, 10'd30, 30);

    // Back-to-back with req held high throughout.
    x = 32'h2000_0000;
    y = 32'h0;
    max_iterations = 10'd100;
    req = 1'b1;
    tick();
    check("b2b_ack1", 32'(ack), 32'd1);
    x = 32'h5000_0000;
    max_iterations = 10'd50;
    wait_done("b2b1", lat, nb, na);
    check("b2b_count1", 32'(iteration_count_out), 32'd3);
    check("b2b_no_reack", 32'(na), 32'd0);
    tick();
    check("b2b_ack2", 32'(ack), 32'd1);
    req = 1'b0;
    wait_done("b2b2", lat, nb, na);
    check("b2b_count2", 32'(iteration_count_out), 32'd1);
    check("b2b_lat2", 32'(lat), 32'd2);

    // Reset in the middle of a long iteration.
    x = 32'h0;
    y = 32'h0;
    max_iterations = 10'd1023;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    req = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_count", 32'(iteration_count_out), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    req = 1'b0;
    na = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) na++;
    end
    check("mid_rst_quiet", 32'(na), 32'd0);
    run_point("after_rst", 32'h2000_0000, 32'h0, 10'd100, 3);

    for (int k = 0; k < 12; k++) begin
      r  = $urandom;
      rx = {{2{r[30]}}, r[29:0]};
      r  = $urandom;
      ry = {{2{r[30]}}, r[29:0]};
      rm = 10'($urandom_range(1, 255));
      exp = model(rx, ry, int'(rm));
      run_point($sformatf("rand%0d", k), rx, ry, rm, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
